data_memory_mc: RTL and testbench
=================================

// Module: data_memory_mc
// PURPOSE
//  Parametrised multi-cycle data memory for the MEM stage. Supports byte, half and word
//  loads and stores. Loads can be sign- or zero-extended. Misaligned accesses are detected.
//  Access latency is configurable, and a ready/busy handshake lets the pipeline stall
//  until each access completes. Memory is byte-addressed and stored as DEPTH words of 32 bits.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; power of two, >= 4
//  LATENCY  2    cycles from request acceptance to ready; 1..15
//  ADDR_W   32   width of the byte address input
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  address     in   ADDR_W  byte address; word index = address[log2(DEPTH)+1:2] (upper bits ignored, wraps)
//  write_data  in   32      store data; byte/half taken from bits [7:0]/[15:0]
//  mem_read    in   1       load request
//  mem_write   in   1       store request
//  size        in   2       00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
//  sign_ext    in   1       1: sign-extend byte/half loads; 0: zero-extend
//  read_data   out  32      load result; valid while ready=1, held until the next acceptance
//  ready       out  1       one-cycle completion pulse
//  busy        out  1       access in flight; the pipeline stalls on busy | (req & ~ready)
//  misalign    out  1       valid with ready; 1 = access rejected
// BEHAVIOUR
//  - Reset values: state=IDLE; read_data=0; ready=0; busy=0; misalign=0; counter=0.
//    Memory contents are not altered by reset.
//  - req = mem_read | mem_write. If both are high, the request is a store
//    (mem_write wins); no read is performed.
//  - FSM states:
//    IDLE: on a clk edge with req=1, latch address, write_data, size, sign_ext and op.
//          If LATENCY=1, go to DONE; otherwise go to WAIT with counter=LATENCY-1.
//          With req=0, stay in IDLE.
//    WAIT: decrement the counter each cycle. When counter reaches 1, go to DONE.
//          Inputs are ignored while in WAIT.
//    DONE: ready=1 for exactly one cycle. The store is committed at the DONE edge.
//          The next state is IDLE; a new req can be accepted on the following edge.
//  - Latency and throughput: a request accepted at edge t gives ready=1 in the cycle
//    after edge t+LATENCY. Throughput is one access per LATENCY+1 cycles.
//    busy=1 in WAIT and DONE.
//  - Misalignment rules: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//    Such an access writes no memory and leaves read_data=0; misalign=1 with ready.
//    It still takes the full LATENCY.
//  - Store lane selection: byte writes only lane addr[1:0] (bits 8*k+7:8*k).
//    Half writes only lanes {addr[1],0} and {addr[1],1}. Word writes all 4 lanes.
//    Other lanes are preserved.
//  - Load extraction: a byte load extracts lane addr[1:0]; a half load extracts bits
//    [16*addr[1]+15 : 16*addr[1]]. The result is extended per sign_ext.
//  - Store completion: read_data=0 when a store completes.
//  - Endianness: little-endian (byte 0 = bits [7:0]).
//  - Address wrap: addresses beyond 4*DEPTH alias modulo 4*DEPTH; no error is raised.
//  - Reset mid-operation: rst in WAIT or DONE aborts the access. No write is committed,
//    ready stays 0 and the FSM returns to IDLE.
//  - Inputs changing after acceptance have no effect on the in-flight access.
// TESTING
//  1. LATENCY=2: store word 0xDEADBEEF @0x10 at edge t. Expect ready in cycle t+2,
//     then read @0x10. Expect read_data=0xDEADBEEF and misalign=0.
//  2. Store byte 0x80 @0x13 into word 0x11223344, then:
//     signed lb @0x13 -> 0xFFFFFF80; unsigned lb @0x13 -> 0x00000080;
//     lw @0x10 -> 0x80223344.
//  3. lh @0x12 with sign_ext=1 on word 0x80223344 -> 0xFFFF8022.
//     sw @0x06 -> ready with misalign=1, memory unchanged, read_data=0.
//  4. Assert mem_read and mem_write together: the store happens, and read_data=0 at ready.
//     Store @0x400 with DEPTH=256 -> readback @0x000 returns the same data.
//  5. Assert rst one cycle after accepting a sw 0x12345678 @0x20. Expect ready never
//     pulses, busy=0 after the reset edge, and a later lw @0x20 returns the old value.
//  6. Back-to-back requests held high continuously with LATENCY=1: exactly one ready per
//     2 cycles. Inputs changed during WAIT have no effect on the in-flight result.

Source files
------------

// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressed data memory: byte/half/word loads and stores, sign/zero extension.
// Each access occupies LATENCY cycles plus one ready cycle; misaligned accesses complete with misalign=1.
module data_memory_mc #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              busy,
  output logic              misalign
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic          wr_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          busy_q;
  logic          mis_q;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          mis_d;
  logic [AW-1:0] widx;
  logic [31:0]   cur_w;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_d;
  logic [3:0]    be_d;
  logic [31:0]   wlane_d;
  logic [31:0]   rdata_d;

  // Address bits above the memory span alias, so they are deliberately dropped.
  if (ADDR_W > AW + 2) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^address[ADDR_W-1:AW+2];
  end

  assign req  = mem_read | mem_write;
  assign widx = addr_q[AW+1:2];

  always_comb begin
    mis_d    = (size_q == 2'b11)
             | ((size_q == 2'b01) && addr_q[0])
             | ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    cur_w    = mem[widx];
    byte_sel = cur_w[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? cur_w[31:16] : cur_w[15:0];
    case (size_q)
      2'b00:   load_d = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_d = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_d = cur_w;
    endcase
    case (size_q)
      2'b00: begin
        be_d    = 4'b0001 << addr_q[1:0];
        wlane_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{wdata_q[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wlane_d = wdata_q;
      end
    endcase
    rdata_d = (wr_q || mis_d) ? 32'h0 : load_d;
  end

  // Memory is outside reset; a reset during DONE suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_DONE) && wr_q && !mis_d) begin
      for (int k = 0; k < 4; k++) begin
        if (be_d[k]) mem[widx][8*k +: 8] <= wlane_d[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= address[AW+1:0];
            wdata_q <= write_data;
            size_q  <= size;
            sext_q  <= sign_ext;
            wr_q    <= mem_write;
            busy_q  <= 1'b1;
            if (LATENCY == 1) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          mis_q   <= mis_d;
          rdata_q <= rdata_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data = rdata_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign misalign  = mis_q;

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench for data_memory_mc: LATENCY=2 instance for functional cases, LATENCY=1 for throughput.
module tb_data_memory_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr, wdat, rdat;
  logic        mrd, mwr, sext, rdy, bsy, mis;
  logic [1:0]  sz;

  logic [31:0] a1, d1, rd1;
  logic        mr1, mw1, se1, rdy1, bsy1, mis1;
  logic [1:0]  s1;

  int total = 0;
  int bad   = 0;

  data_memory_mc #(.DEPTH(256), .LATENCY(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .address(addr), .write_data(wdat),
    .mem_read(mrd), .mem_write(mwr), .size(sz), .sign_ext(sext),
    .read_data(rdat), .ready(rdy), .busy(bsy), .misalign(mis)
  );

  data_memory_mc #(.DEPTH(256), .LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst), .address(a1), .write_data(d1),
    .mem_read(mr1), .mem_write(mw1), .size(s1), .sign_ext(se1),
    .read_data(rd1), .ready(rdy1), .busy(bsy1), .misalign(mis1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge, scramble inputs after acceptance, wait for ready.
  task automatic acc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic se,
                     output logic [31:0] r, output logic m, output int lat);
    int n;
    n = 0; lat = -1; r = 32'h0; m = 1'b0;
    addr = a; wdat = d; mrd = rd; mwr = wr; sz = s; sext = se;
    repeat (20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        mrd = 1'b0; mwr = 1'b0; addr = 32'hFFFF_FFFC; wdat = 32'h0; sz = 2'b11; sext = ~se;
      end
      if (rdy) begin
        r = rdat; m = mis; lat = n - 1;
        break;
      end
    end
    if (lat < 0) chk("ready_timeout", {31'b0, rdy}, 32'd1);
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] s, input logic se,
                    input logic [31:0] exp, input logic expm);
    logic [31:0] r; logic m; int l;
    acc(1'b1, 1'b0, a, 32'h0, s, se, r, m, l);
    chk({tag, "_data"}, r, exp);
    chk({tag, "_mis"}, {31'b0, m}, {31'b0, expm});
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] s, input logic expm);
    logic [31:0] r; logic m; int l;
    acc(1'b0, 1'b1, a, d, s, 1'b0, r, m, l);
    chk({tag, "_rdata"}, r, 32'h0);
    chk({tag, "_mis"}, {31'b0, m}, {31'b0, expm});
  endtask

  initial begin
    logic [31:0] r;
    logic        m;
    int          l, pulses, gaps, lastn, k;

    rst = 1'b1;
    addr = 0; wdat = 0; mrd = 0; mwr = 0; sz = 2'b10; sext = 0;
    a1 = 0; d1 = 0; mr1 = 0; mw1 = 0; s1 = 2'b10; se1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdat, 32'h0);
    chk("rst_ready", {31'b0, rdy}, 32'd0);
    chk("rst_busy", {31'b0, bsy}, 32'd0);
    chk("rst_mis", {31'b0, mis}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store latency and readback
    acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, r, m, l);
    chk("t1_st_lat", 32'(l), 32'd2);
    chk("t1_st_mis", {31'b0, m}, 32'd0);
    acc(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, r, m, l);
    chk("t1_ld_lat", 32'(l), 32'd2);
    chk("t1_ld_data", r, 32'hDEADBEEF);

    // Byte store into lane 3, signed/unsigned byte loads, halves
    st("t2_sw", 32'h10, 32'h11223344, 2'b10, 1'b0);
    st("t2_sb", 32'h13, 32'hAAAAAA80, 2'b00, 1'b0);
    ld("t2_lb", 32'h13, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
    ld("t2_lbu", 32'h13, 2'b00, 1'b0, 32'h00000080, 1'b0);
    ld("t2_lw", 32'h10, 2'b10, 1'b0, 32'h80223344, 1'b0);
    ld("t3_lh", 32'h12, 2'b01, 1'b1, 32'hFFFF8022, 1'b0);
    ld("t3_lhu", 32'h12, 2'b01, 1'b0, 32'h00008022, 1'b0);
    ld("t3_lh_lo", 32'h10, 2'b01, 1'b1, 32'h00003344, 1'b0);

    // Misalignment leaves memory untouched; aligned upper half store keeps low lanes
    st("t3_sw4", 32'h04, 32'hCAFEF00D, 2'b10, 1'b0);
    st("t3_sw6", 32'h06, 32'h11111111, 2'b10, 1'b1);
    ld("t3_chk4", 32'h04, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
    st("t3_sh6", 32'h06, 32'h1234BEEF, 2'b01, 1'b0);
    ld("t3_lw4", 32'h04, 2'b10, 1'b0, 32'hBEEFF00D, 1'b0);
    ld("t3_rsv", 32'h04, 2'b11, 1'b0, 32'h0, 1'b1);
    ld("t3_lw11", 32'h11, 2'b10, 1'b0, 32'h0, 1'b1);
    ld("t3_lh13", 32'h13, 2'b01, 1'b0, 32'h0, 1'b1);

    // Read+write together is a store; address aliasing
    acc(1'b1, 1'b1, 32'h20, 32'h0BADF00D, 2'b10, 1'b0, r, m, l);
    chk("t4_rw_rdata", r, 32'h0);
    ld("t4_rw_chk", 32'h20, 2'b10, 1'b0, 32'h0BADF00D, 1'b0);
    st("t4_wrap_st", 32'h400, 32'h5A5A1234, 2'b10, 1'b0);
    ld("t4_wrap_ld", 32'h000, 2'b10, 1'b0, 32'h5A5A1234, 1'b0);

    // Reset one cycle after acceptance aborts the store
    addr = 32'h20; wdat = 32'h12345678; mwr = 1'b1; sz = 2'b10;
    @(negedge clk);
    mwr = 1'b0; rst = 1'b1;
    chk("t5_busy_pre", {31'b0, bsy}, 32'd1);
    @(negedge clk);
    chk("t5_busy_post", {31'b0, bsy}, 32'd0);
    chk("t5_ready_post", {31'b0, rdy}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy) pulses++;
    end
    chk("t5_no_ready", 32'(pulses), 32'd0);
    ld("t5_old", 32'h20, 2'b10, 1'b0, 32'h0BADF00D, 1'b0);

    // LATENCY=1, store request held high with data changing every cycle
    a1 = 32'h8; s1 = 2'b10; d1 = 32'd0; mw1 = 1'b1;
    pulses = 0; gaps = 0; lastn = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdy1) begin
        pulses++;
        if (n - lastn != 2) gaps++;
        lastn = n;
      end
      d1 = 32'(n);
      if (n == 20) mw1 = 1'b0;
    end
    chk("t6_ready_cnt", 32'(pulses), 32'd10);
    chk("t6_ready_gap", 32'(gaps), 32'd0);
    mr1 = 1'b1; d1 = 32'hFFFFFFFF;
    k = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin mr1 = 1'b0; a1 = 32'h0; end
      if (rdy1) begin k = n; break; end
    end
    chk("t6_rd_lat", 32'(k), 32'd2);
    chk("t6_rd_data", rd1, 32'd18);
    chk("t6_rd_mis", {31'b0, mis1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
